// File: rtl/lsu_mem_master_if.sv
// lsu_mem_master_if
//   Bundles the three channels around the load/store initiator:
//     req_*  : execute stage -> LSU access request
//     resp_* : LSU -> execute stage response (loads and stores)
//     mem_*  : LSU -> data memory single-cycle access, mem_rdata returned
//              combinationally in the same cycle as mem_valid
//   Modports:
//     master : the LSU view (consumes requests, produces responses, drives memory)
//     slave  : the environment view (execute stage plus memory model)
//
//   Handshake rule (req and resp channels): a transfer happens at the rising
//   clock edge where valid and ready are both 1. The producer holds valid and
//   its payload stable until that edge; ready may depend combinationally on
//   the consumer's own state only, never on valid.
interface lsu_mem_master_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_wen;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [1:0]        req_size;
   logic              req_unsigned;

   logic              resp_valid;
   logic              resp_ready;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_err;

   logic              mem_valid;
   logic              mem_wen;
   logic [ADDR_W-1:0] mem_raddr;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic [7:0]        mem_wmask;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      input  req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned,
      output req_ready,
      output resp_valid, resp_rdata, resp_err,
      input  resp_ready,
      output mem_valid, mem_wen, mem_raddr, mem_waddr, mem_wdata, mem_wmask,
      input  mem_rdata
   );

   modport slave (
      output req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned,
      input  req_ready,
      input  resp_valid, resp_rdata, resp_err,
      output resp_ready,
      input  mem_valid, mem_wen, mem_raddr, mem_waddr, mem_wdata, mem_wmask,
      output mem_rdata
   );
endinterface

// File: rtl/lsu_mem_master.sv
// lsu_mem_master
//   Load/store initiator for the core's data memory port. Accepts one byte,
//   halfword or word access, issues exactly one word-aligned memory access,
//   then returns lane-aligned, sign/zero-extended load data (0 for stores).
//   One outstanding request at a time; back-to-back requests run at one
//   memory access every two cycles.
//
//   Ports:
//     clk        clock
//     resetn     synchronous reset, active-low
//     bus        lsu_mem_master_if.master (req_*, resp_*, mem_* channels)
//     dbg_state  current FSM state (0 = IDLE, 1 = ACCESS, 2 = RESP)
//
//   Build option:
//     LSU_ALIGN_CHECK_EN  when defined, misaligned half/word requests skip the
//                         memory access and answer with resp_err = 1. When not
//                         defined, resp_err is tied 0 and low address bits are
//                         ignored for halfword (bit 0) and word (bits 1:0).
module lsu_mem_master #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                   clk,
   input  logic                   resetn,
   lsu_mem_master_if.master       bus,
   output logic [1:0]             dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic              wen_q, wen_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic              resp_valid_q, resp_valid_d;
   logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;

   logic              req_ready;
   logic              accept;
   logic              req_mis;
   logic              in_access;
   logic [1:0]        eoff;
   logic [4:0]        lane_shamt;
   logic [3:0]        lane_mask;
   logic [DATA_W-1:0] load_sh;
   logic [DATA_W-1:0] load_ext;

`ifdef LSU_ALIGN_CHECK_EN
   logic              resp_err_q, resp_err_d;

   // Misalignment is judged on the incoming request so it can bypass ACCESS.
   assign req_mis = ((bus.req_size == 2'd1) & bus.req_addr[0]) |
                    (bus.req_size[1] & (bus.req_addr[1:0] != 2'b00));
`else
   assign req_mis = 1'b0;
`endif

   assign accept = bus.req_valid & req_ready;

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q      <= ST_IDLE;
         wen_q        <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         size_q       <= 2'd0;
         uns_q        <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
`ifdef LSU_ALIGN_CHECK_EN
         resp_err_q   <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         wen_q        <= wen_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         size_q       <= size_d;
         uns_q        <= uns_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
`ifdef LSU_ALIGN_CHECK_EN
         resp_err_q   <= resp_err_d;
`endif
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) state_d = req_mis ? ST_RESP : ST_ACCESS;
         end
         ST_ACCESS: begin
            state_d = ST_RESP;
         end
         ST_RESP: begin
            // A new request accepted on the response handshake edge keeps
            // the pipe full instead of bouncing through IDLE.
            if (bus.resp_ready) begin
               if (accept) state_d = req_mis ? ST_RESP : ST_ACCESS;
               else        state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Lane steering for the latched request
   // ------------------------------------------------------------------
   always_comb begin
      eoff      = 2'd0;
      lane_mask = 4'b1111;
      case (size_q)
         2'd0: begin
            eoff      = addr_q[1:0];
            lane_mask = 4'b0001 << addr_q[1:0];
         end
         2'd1: begin
            eoff      = {addr_q[1], 1'b0};
            lane_mask = 4'b0011 << {addr_q[1], 1'b0};
         end
         default: begin
            eoff      = 2'd0;
            lane_mask = 4'b1111;
         end
      endcase
      lane_shamt = {eoff, 3'b000};
      load_sh    = bus.mem_rdata >> lane_shamt;
      case (size_q)
         2'd0:    load_ext = {{(DATA_W-8){load_sh[7] & ~uns_q}}, load_sh[7:0]};
         2'd1:    load_ext = {{(DATA_W-16){load_sh[15] & ~uns_q}}, load_sh[15:0]};
         default: load_ext = load_sh;
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath next-values
   // ------------------------------------------------------------------
   always_comb begin
      wen_d        = wen_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      size_d       = size_q;
      uns_d        = uns_q;
      resp_rdata_d = resp_rdata_q;
`ifdef LSU_ALIGN_CHECK_EN
      resp_err_d   = resp_err_q;
`endif
      if (accept) begin
         wen_d   = bus.req_wen;
         addr_d  = bus.req_addr;
         wdata_d = bus.req_wdata;
         size_d  = bus.req_size;
         uns_d   = bus.req_unsigned;
      end
      // A response is pending exactly while the FSM sits in RESP.
      resp_valid_d = (state_d == ST_RESP);
      if (state_q == ST_ACCESS) begin
         resp_rdata_d = wen_q ? '0 : load_ext;
`ifdef LSU_ALIGN_CHECK_EN
         resp_err_d   = 1'b0;
`endif
      end else if (accept & req_mis) begin
         resp_rdata_d = '0;
`ifdef LSU_ALIGN_CHECK_EN
         resp_err_d   = 1'b1;
`endif
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   always_comb begin
      in_access      = (state_q == ST_ACCESS);
      req_ready      = (state_q == ST_IDLE) | ((state_q == ST_RESP) & bus.resp_ready);
      bus.req_ready  = req_ready;
      // Gated by resetn so a store caught in ACCESS by reset never commits.
      bus.mem_valid  = resetn & in_access;
      bus.mem_wen    = in_access & wen_q;
      bus.mem_raddr  = in_access ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
      bus.mem_waddr  = in_access ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
      bus.mem_wdata  = in_access ? (wdata_q << lane_shamt) : '0;
      bus.mem_wmask  = in_access ? {4'b0000, lane_mask} : 8'h00;
      bus.resp_valid = resp_valid_q;
      bus.resp_rdata = resp_rdata_q;
`ifdef LSU_ALIGN_CHECK_EN
      bus.resp_err   = resp_err_q;
`else
      bus.resp_err   = 1'b0;
`endif
      dbg_state      = state_q;
   end

endmodule
